// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the inter-stage pipeline registers.
// Holds the control-bundle bit map, default bundle widths per stage and
// the skid-buffer FSM encoding used when PIPE_SKID_BUFFER_EN is defined.
package pipe_pkg;

  // Generic defaults for a pipe_stage_reg instance
  localparam int DATA_W_DEF      = 96;
  localparam int CTRL_W_DEF      = 16;
  localparam int STALL_CNT_W_DEF = 16;

  // Per-stage bundle widths
  localparam int IF_ID_DATA_W  = 64;  // pc + instruction
  localparam int IF_ID_CTRL_W  = 4;
  localparam int ID_EX_DATA_W  = 128; // pc, rs1, rs2, imm
  localparam int ID_EX_CTRL_W  = 16;
  localparam int EX_MEM_DATA_W = 96;  // alu result, store data, pc
  localparam int EX_MEM_CTRL_W = 8;
  localparam int MEM_WB_DATA_W = 64;  // writeback value, pc
  localparam int MEM_WB_CTRL_W = 4;

  // Control-bundle bit positions; an all-zero bundle is a bubble
  localparam int REG_WRITE_BIT = 0;
  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_WRITE_BIT = 2;
  localparam int BRANCH_BIT    = 3;
  localparam int JUMP_BIT      = 4;
  localparam int ALU_OP_LSB    = 5;
  localparam int ALU_OP_MSB    = 8;

  // Skid-buffer occupancy states
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: 2-entry storage (output entry + skid entry) with an
// occupancy FSM. in_ready_o comes straight from a flop so the upstream
// stage never sees a combinational path from out_ready_i.
// Used by pipe_stage_reg only when PIPE_SKID_BUFFER_EN is defined.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o
);

  skid_state_e       state_reg, state_next;
  logic              ready_reg, ready_next;
  logic [DATA_W-1:0] out_data_reg, skid_data_reg;
  logic [CTRL_W-1:0] out_ctrl_reg, skid_ctrl_reg;
  logic              accept, emit;
  logic              load_out, load_skid, move_skid;

  assign accept = in_valid_i & ready_reg;
  assign emit   = (state_reg != EMPTY) & out_ready_i;

  // State register plus the registered ready flag
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg <= EMPTY;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      ready_reg <= ready_next;
    end
  end

  // Next-state logic; flush always returns to EMPTY
  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY:   if (accept) state_next = FULL;
        FULL: begin
          if (accept && !emit)      state_next = SKID;
          else if (!accept && emit) state_next = EMPTY;
        end
        SKID:    if (emit) state_next = FULL;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Output / datapath-control decode
  always_comb begin
    ready_next  = (state_next != SKID);
    out_valid_o = (state_reg != EMPTY);
    load_out    = !flush_i && accept &&
                  ((state_reg == EMPTY) || ((state_reg == FULL) && emit));
    load_skid   = !flush_i && accept && (state_reg == FULL) && !emit;
    move_skid   = !flush_i && emit && (state_reg == SKID);
  end

  // Entry storage; data is kept across flush, control bundles are cleared
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_data_reg  <= '0;
      out_ctrl_reg  <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
    end else if (flush_i) begin
      out_ctrl_reg  <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      if (load_out) begin
        out_data_reg <= in_data_i;
        out_ctrl_reg <= in_ctrl_i;
      end else if (move_skid) begin
        out_data_reg <= skid_data_reg;
        out_ctrl_reg <= skid_ctrl_reg;
      end
      if (load_skid) begin
        skid_data_reg <= in_data_i;
        skid_ctrl_reg <= in_ctrl_i;
      end
    end
  end

  assign in_ready_o = ready_reg;
  assign out_data_o = out_data_reg;
  assign out_ctrl_o = out_ctrl_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage register with valid/ready
// handshake, synchronous flush (control bundle zeroed -> bubble) and a
// saturating stall counter for performance debug.
// Build option PIPE_SKID_BUFFER_EN selects a 2-entry skid buffer with a
// registered in_ready_o; otherwise a single entry with combinational ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CTRL_W      = CTRL_W_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      in_data_i,
  input  logic [CTRL_W-1:0]      in_ctrl_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [CTRL_W-1:0]      out_ctrl_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  logic                   stage_valid;
  logic [DATA_W-1:0]      stage_data;
  logic [CTRL_W-1:0]      stage_ctrl;
  logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

`ifdef PIPE_SKID_BUFFER_EN
  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_ctrl_i   (in_ctrl_i),
    .out_valid_o (stage_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (stage_data),
    .out_ctrl_o  (stage_ctrl)
  );
`else
  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  // Single entry can take a new beat whenever it is empty or draining
  assign in_ready_o = !valid_reg | out_ready_i;

  // Entry register: flush beats accept, accept beats emit
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ctrl_reg  <= '0;
    end else if (flush_i) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data_i;
      ctrl_reg  <= in_ctrl_i;
    end else if (valid_reg && out_ready_i) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end
  end

  assign stage_valid = valid_reg;
  assign stage_data  = data_reg;
  assign stage_ctrl  = ctrl_reg;
`endif

  // Stall counter increments on back-pressured edges and sticks at all-ones
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stage_valid && !out_ready_i && !(&stall_cnt_reg))
      stall_cnt_next = stall_cnt_reg + STALL_CNT_W'(1);
  end

  // Stall counter register; cleared only by reset, not by flush
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) stall_cnt_reg <= '0;
    else          stall_cnt_reg <= stall_cnt_next;
  end

  // Downstream sees an all-zero control bundle whenever no beat is valid
  assign out_valid_o = stage_valid;
  assign out_data_o  = stage_data;
  assign out_ctrl_o  = stage_valid ? stage_ctrl : '0;
  assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// Works for both builds; PIPE_SKID_BUFFER_EN selects the skid expectations.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [2:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .DATA_W      (32),
    .CTRL_W      (16),
    .STALL_CNT_W (3)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_ctrl_i   (in_ctrl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ctrl_o  (out_ctrl),
    .stall_cnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 0; in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 1;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    flush = 0; in_valid = 1; in_data = 32'hDEAD; in_ctrl = 16'hFFFF; out_ready = 0;
    rst_n = 0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || stall_cnt !== 3'd0 ||
        in_ready !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: valid=%b ctrl=%h cnt=%0d ready=%b data=%h, want 0/0000/0/1/0",
               out_valid, out_ctrl, stall_cnt, in_ready, out_data);
    end
    in_valid = 0;
    rst_n = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: valid=%b want 0", out_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = i; in_ctrl = 16'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || out_ctrl !== 16'(i)) begin
        errors++;
        $display("FAIL stream_beat%0d: valid=%b data=%h ctrl=%h want 1/%h/%h",
                 i, out_valid, out_data, out_ctrl, i, i);
      end else begin
        $display("stream beat %0d data=%h", i, out_data);
      end
    end
    in_valid = 0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || stall_cnt !== 3'd0) begin
      errors++;
      $display("FAIL stream_drain: valid=%b ctrl=%h cnt=%0d want 0/0000/0",
               out_valid, out_ctrl, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1; in_valid = 1; in_data = 32'hA5; in_ctrl = 16'h1;
    tick();
    out_ready = 0; in_data = 32'h5A; in_ctrl = 16'h2;
    #1;
    checks++;
`ifdef PIPE_SKID_BUFFER_EN
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_full: in_ready=%b want 1", in_ready);
    end
`else
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_comb: in_ready=%b want 0", in_ready);
    end
`endif
    for (int k = 1; k <= 3; k++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5 || out_ctrl !== 16'h1 || stall_cnt !== 3'd3) begin
      errors++;
      $display("FAIL bp_hold: valid=%b data=%h ctrl=%h cnt=%0d want 1/a5/0001/3",
               out_valid, out_data, out_ctrl, stall_cnt);
    end
`ifdef PIPE_SKID_BUFFER_EN
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_skid: in_ready=%b want 0", in_ready);
    end
`endif
    out_ready = 1;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h5A || out_ctrl !== 16'h2) begin
      errors++;
      $display("FAIL bp_second_beat: valid=%b data=%h ctrl=%h want 1/5a/0002",
               out_valid, out_data, out_ctrl);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 3'd3) begin
      errors++;
      $display("FAIL bp_no_dup: valid=%b cnt=%0d want 0/3", out_valid, stall_cnt);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0; in_valid = 1; in_data = 32'h11; in_ctrl = 16'hFFFF;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 16'hFFFF) begin
      errors++;
      $display("FAIL flush_pre: valid=%b ctrl=%h want 1/ffff", out_valid, out_ctrl);
    end
    tick();  // one stall edge
    flush = 1; out_ready = 1; in_valid = 1; in_data = 32'h22; in_ctrl = 16'hFFFF;
    tick();
    flush = 0; in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || in_ready !== 1'b1 ||
        out_data !== 32'h11 || stall_cnt !== 3'd1) begin
      errors++;
      $display("FAIL flush_post: valid=%b ctrl=%h ready=%b data=%h cnt=%0d want 0/0000/1/11/1",
               out_valid, out_ctrl, in_ready, out_data, stall_cnt);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h11) begin
      errors++;
      $display("FAIL flush_dropped: valid=%b data=%h want 0/11", out_valid, out_data);
    end
    $display("test_flush done");
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 0; in_valid = 1; in_data = 32'h33; in_ctrl = 16'h4;
    tick();
    in_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (stall_cnt !== ((k < 7) ? 3'(k) : 3'd7)) begin
        errors++;
        $display("FAIL sat_cnt_cycle%0d: cnt=%0d want %0d", k, stall_cnt, (k < 7) ? k : 7);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h33) begin
      errors++;
      $display("FAIL sat_hold: valid=%b data=%h want 1/33", out_valid, out_data);
    end
    $display("test_saturation done, cnt=%0d", stall_cnt);
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 0; in_valid = 1; in_data = 32'h44; in_ctrl = 16'h1;
    tick();
    in_data = 32'h55; in_ctrl = 16'h2;
    tick();
    in_valid = 0;
    tick();
`ifdef PIPE_SKID_BUFFER_EN
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_in_skid: in_ready=%b want 0", in_ready);
    end
`endif
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || stall_cnt !== 3'd0 ||
        in_ready !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b ctrl=%h cnt=%0d ready=%b data=%h want 0/0000/0/1/0",
               out_valid, out_ctrl, stall_cnt, in_ready, out_data);
    end
    #1;
    rst_n = 1;
    tick();
    out_ready = 1; in_valid = 1; in_data = 32'h77; in_ctrl = 16'h3;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h77 || out_ctrl !== 16'h3) begin
      errors++;
      $display("FAIL async_first_beat: valid=%b data=%h ctrl=%h want 1/77/0003",
               out_valid, out_data, out_ctrl);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_after_beat: valid=%b want 0", out_valid);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
